// File: rtl/user_module_339898704941023827_pkg.sv
// Shared constants for the prescaled BCD up/down counter with seven-segment output.
package user_module_339898704941023827_pkg;

  localparam int unsigned PSC_W = 15;

  typedef logic [3:0]       digit_t;
  typedef logic [6:0]       seg_t;
  typedef logic [PSC_W-1:0] psc_t;

  localparam digit_t DIGIT_MAX = 4'd9;

  // Active-high segments, bit0 = a ... bit6 = g
  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_OFF = 7'h00;

  // 2^n - 1 over the prescaler width; n = 15 yields all ones.
  function automatic psc_t prescale_mask(input logic [3:0] n);
    logic [PSC_W:0] one_hot;
    logic [PSC_W:0] full;
    one_hot = (PSC_W+1)'(1) << n;
    full    = one_hot - (PSC_W+1)'(1);
    return full[PSC_W-1:0];
  endfunction

endpackage

// File: rtl/user_module_339898704941023827_seg7_decode.sv
// Combinational BCD digit to seven-segment decoder; illegal codes blank the display.
module seg7_decode
  import user_module_339898704941023827_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/user_module_339898704941023827.sv
// Prescaled BCD up/down counter driving a seven-segment display; dp toggles on each wrap.
module user_module_339898704941023827
  import user_module_339898704941023827_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic [3:0] psel;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign en   = io_in[2];
  assign up   = io_in[3];
  assign psel = io_in[7:4];

  psc_t   psc_q;
  digit_t digit_q;
  logic   wrap_q;

  psc_t   mask;
  logic   tick;
  digit_t digit_next;
  logic   wrap_hit;

  // Only the low psel bits take part in the compare, so a psel change acts at once.
  assign mask = prescale_mask(psel);
  assign tick = en && ((psc_q & mask) == mask);

  always_comb begin
    digit_next = digit_q;
    wrap_hit   = 1'b0;
    if (up) begin
      if (digit_q >= DIGIT_MAX) begin
        digit_next = '0;
        wrap_hit   = 1'b1;
      end else begin
        digit_next = digit_q + 4'd1;
      end
    end else begin
      if (digit_q == '0) begin
        digit_next = DIGIT_MAX;
        wrap_hit   = 1'b1;
      end else begin
        digit_next = digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q   <= '0;
      digit_q <= '0;
      wrap_q  <= 1'b0;
    end else if (en) begin
      if (tick) begin
        psc_q   <= '0;
        digit_q <= digit_next;
        if (wrap_hit) wrap_q <= ~wrap_q;
      end else begin
        psc_q <= psc_q + PSC_W'(1);
      end
    end
  end

  logic [6:0] seg;

  seg7_decode u_decode (
    .digit (digit_q),
    .seg   (seg)
  );

  assign io_out = {wrap_q, seg};

endmodule

// File: tb/tb_user_module_339898704941023827.sv
// Directed self-checking bench for the prescaled BCD seven-segment counter.
`timescale 1ns/1ps
module tb_user_module_339898704941023827;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic [3:0] psel;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int unsigned vectors;
  int unsigned miscompares;

  assign io_in = {psel, up, en, rst, clk};

  user_module_339898704941023827 dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; psel = 4'd0;
    step();
    rst = 1'b0;
    vectors++;
    if (io_out !== 8'h3F) begin
      miscompares++;
      $display("FAIL reset_value: got %02h expected 3F", io_out);
    end
    for (int i = 0; i < 20; i++) begin
      up   = i[0];
      psel = i[3:0];
      step();
      vectors++;
      if (io_out !== 8'h3F) begin
        miscompares++;
        $display("FAIL hold_en0[%0d]: got %02h expected 3F", i, io_out);
      end
    end
  endtask

  task automatic test_count_up();
    logic [7:0] exp_seq [20];
    exp_seq = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'hBF,
                8'h86, 8'hDB, 8'hCF, 8'hE6, 8'hED, 8'hFD, 8'h87, 8'hFF, 8'hEF, 8'h3F};
    psel = 4'd0; up = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (io_out !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL count_up[%0d]: got %02h expected %02h", i, io_out, exp_seq[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    psel = 4'd0; up = 1'b0;
    do_reset();
    en = 1'b1;
    step();
    vectors++;
    if (io_out !== 8'hEF) begin
      miscompares++;
      $display("FAIL down_wrap: got %02h expected EF", io_out);
    end
    step();
    vectors++;
    if (io_out !== 8'hFF) begin
      miscompares++;
      $display("FAIL down_8: got %02h expected FF", io_out);
    end
    en = 1'b0;
  endtask

  task automatic test_prescale();
    psel = 4'd3; up = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      vectors++;
      if (io_out !== ((i == 8) ? 8'h06 : 8'h3F)) begin
        miscompares++;
        $display("FAIL psc_first[%0d]: got %02h expected %02h", i, io_out,
                 (i == 8) ? 8'h06 : 8'h3F);
      end
    end
    // 3 enabled, 5 stalled, 5 enabled: change lands on the 13th clock.
    for (int i = 1; i <= 13; i++) begin
      en = !(i >= 4 && i <= 8);
      step();
      vectors++;
      if (io_out !== ((i == 13) ? 8'h5B : 8'h06)) begin
        miscompares++;
        $display("FAIL psc_stretch[%0d]: got %02h expected %02h", i, io_out,
                 (i == 13) ? 8'h5B : 8'h06);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_mid_reset();
    psel = 4'd0; up = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (io_out !== 8'h6D) begin
      miscompares++;
      $display("FAIL pre_reset_5: got %02h expected 6D", io_out);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (io_out !== 8'h3F) begin
      miscompares++;
      $display("FAIL mid_reset: got %02h expected 3F", io_out);
    end
    step();
    vectors++;
    if (io_out !== 8'h06) begin
      miscompares++;
      $display("FAIL resume_1: got %02h expected 06", io_out);
    end
    en = 1'b0;
  endtask

  task automatic test_psel_switch();
    psel = 4'd15; up = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (io_out !== 8'h3F) begin
      miscompares++;
      $display("FAIL psel15_hold: got %02h expected 3F", io_out);
    end
    // P=5 now: bit0 set, so N=1 ticks on the very next clock.
    psel = 4'd1;
    step();
    vectors++;
    if (io_out !== 8'h06) begin
      miscompares++;
      $display("FAIL psel_switch_tick: got %02h expected 06", io_out);
    end
    step();
    vectors++;
    if (io_out !== 8'h06) begin
      miscompares++;
      $display("FAIL psel_restart_p: got %02h expected 06", io_out);
    end
    step();
    vectors++;
    if (io_out !== 8'h5B) begin
      miscompares++;
      $display("FAIL psel_next_tick: got %02h expected 5B", io_out);
    end
    en = 1'b0;
  endtask

  task automatic test_direction_change();
    psel = 4'd0; up = 1'b1;
    do_reset();
    en = 1'b1;
    step(); step();
    up = 1'b0;
    step();
    vectors++;
    if (io_out !== 8'h06) begin
      miscompares++;
      $display("FAIL dir_change: got %02h expected 06", io_out);
    end
    en = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; en = 1'b0; up = 1'b1; psel = 4'd0;
    #2;
    test_reset();
    test_count_up();
    test_count_down();
    test_prescale();
    test_mid_reset();
    test_psel_switch();
    test_direction_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/user_module_339898704941023827.md
USER_MODULE_339898704941023827 -- requirements
Module: user_module_339898704941023827

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; both are carried on the packed io_in bus (bits 0 and 1).
REQ-002 io_in[0]  input  1  clock; all state updates on the rising edge.
REQ-003 io_in[1]  input  1  rst; synchronous, active-high.
REQ-004 io_in[2]  input  1  en; 1 = count, 0 = hold all state.
REQ-005 io_in[3]  input  1  up; 1 = count up, 0 = count down.
REQ-006 io_in[7:4]  input  4  psel N (0..15); digit steps once every 2^N enabled clocks.
REQ-007 io_out[6:0]  output  7  seven-segment code of the current digit, active-high, bit0=a ... bit6=g.
REQ-008 io_out[7]  output  1  dp; wrap indicator, toggles on each digit wrap.

Function
REQ-009 SHALL hold a 4-bit BCD digit register D (range 0..9), a 15-bit prescaler P, and a 1-bit wrap flag W.
REQ-010 Tick condition: en=1 and (P AND mask) = mask, with mask = 2^N - 1; N=0 ticks on every enabled clock.
REQ-011 On an enabled clock without tick: P <= P+1; D and W unchanged.
REQ-012 On tick: P <= 0; D steps by +1 if up=1, else by -1.
REQ-013 Wrap: up at D=9 gives D=0 and toggles W; down at D=0 gives D=9 and toggles W; every other step leaves W unchanged.
REQ-014 With en=0: P, D and W hold, regardless of up and psel.
REQ-015 A change of psel mid-count takes effect immediately; P bits above N are ignored by the compare and are cleared on the next tick.
REQ-016 A change of up takes effect at the next tick; there is no direction-change penalty.
REQ-017 io_out[6:0] SHALL be a combinational decode of the registered D, so it is valid in the same cycle D updates (zero extra latency).
REQ-018 Decode table (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-019 Illegal D values 10..15 are unreachable; if present they SHALL decode to 0x00.
REQ-020 io_out[7] SHALL equal W.

Reset
REQ-021 rst=1 at a rising edge SHALL set D=0, P=0 and W=0, giving io_out=0x3F from that edge on.
REQ-022 rst SHALL override en, up and psel, including in the middle of a count.
REQ-023 Before the first reset, outputs are don't-care.

Structure
REQ-024 Shared package: the segment-code constants for digits 0..9, the DIGIT_MAX=9 constant and the prescaler width (15).
REQ-025 One sub-module, seg7_decode: 4-bit digit in, 7-bit segments out, purely combinational.
REQ-026 The top level SHALL contain only the prescaler, the digit/wrap registers and the decoder instance; no latches, a single clock domain.

Verification
REQ-027 Apply a rst pulse on one edge (en=0) -> io_out=0x3F; with en=0 held for 20 cycles, io_out stays 0x3F.
REQ-028 en=1, up=1, N=0, run 10 clocks after reset -> io_out steps 06,5B,4F,66,6D,7D,07,7F,6F, then 0xBF (digit 0, dp=1).
REQ-029 en=1, up=0, N=0, one clock from reset -> io_out=0xEF (digit 9, dp=1); next clock -> 0xFF (digit 8, dp=1).
REQ-030 en=1, up=1, N=3 -> first digit change occurs on the 8th enabled clock after reset, then every 8 clocks; drop en for 5 clocks mid-interval -> the interval stretches by exactly 5.
REQ-031 Count up to D=5, assert rst for one edge while en=1 -> io_out=0x3F on that edge and counting resumes from 0 with W=0.
REQ-032 N=15 with P advanced past 3, then switch to N=1 -> a tick occurs within 2 clocks and P restarts from 0.
